// File: rtl/mcp_spi_pkg.sv
// Shared definitions for the MCP492x SPI DAC transmit path: FSM states,
// command word layout and a helper that assembles the 16-bit DAC command.
package mcp_spi_pkg;

    localparam int DAC_WORD_W = 16;
    localparam int DAC_DATA_W = 12;

    localparam int CMD_AB_BIT   = 15;
    localparam int CMD_BUF_BIT  = 14;
    localparam int CMD_GA_BIT   = 13;
    localparam int CMD_SHDN_BIT = 12;
    localparam int CMD_DATA_MSB = 11;
    localparam int CMD_DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LDAC  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    function automatic logic [DAC_WORD_W-1:0] build_cmd(
        input logic                  ab,
        input logic                  vref_buf,
        input logic                  ga_n,
        input logic                  shdn_n,
        input logic [DAC_DATA_W-1:0] data
    );
        logic [DAC_WORD_W-1:0] w;
        w                            = '0;
        w[CMD_AB_BIT]                = ab;
        w[CMD_BUF_BIT]               = vref_buf;
        w[CMD_GA_BIT]                = ga_n;
        w[CMD_SHDN_BIT]              = shdn_n;
        w[CMD_DATA_MSB:CMD_DATA_LSB] = data;
        return w;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock divider: registered sck level plus one-cycle rise/fall strikes that
// mark the edge at which sck changes. Disabled => counter cleared, sck low.
module spi_sck_gen #(
    parameter int unsigned SCK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic stop,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int unsigned HALF  = SCK_DIV / 2;
    localparam int unsigned DIV_W = $clog2(SCK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;

    always_comb begin
        rise  = en && (div_q == DIV_W'(HALF - 1));
        fall  = en && (div_q == DIV_W'(SCK_DIV - 1));
        div_d = '0;
        sck_d = 1'b0;
        if (en) begin
            div_d = fall ? '0 : div_q + DIV_W'(1);
            sck_d = sck_q;
            // stop suppresses the level change but the strike still marks the boundary
            if (rise && !stop) begin
                sck_d = 1'b1;
            end else if (fall) begin
                sck_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/mcp4921_spi_m_axis_sink.sv
// AXI4-Stream sink serialising one 16-bit MCP492x command per accepted sample, then pulsing ldac.
// First sck rise HALF clk after handshake; tready low from handshake until the post-ldac gap ends.
module mcp4921_spi_m_axis_sink
    import mcp_spi_pkg::*;
#(
    parameter int unsigned SCK_DIV   = 10,
    parameter logic        CH        = 1'b0,
    parameter logic        BUF       = 1'b0,
    parameter logic        GA_N      = 1'b1,
    parameter logic        SHDN_N    = 1'b1,
    parameter int unsigned LDAC_CLKS = 2,
    parameter int unsigned GAP_CLKS  = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DAC_WORD_W-1:0] s_axis_dac_tdata,
    input  logic                  s_axis_dac_tvalid,
    output logic                  s_axis_dac_tready,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    output logic                  ldac
);

    localparam int unsigned DLY_MAX = (LDAC_CLKS > GAP_CLKS) ? LDAC_CLKS : GAP_CLKS;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

    state_e                state_q, state_d;
    logic [DAC_WORD_W-1:0] word_q, word_d;
    logic [3:0]            bit_q, bit_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  ldac_q, ldac_d;
    logic                  tready_q, tready_d;

    logic sck_en, sck_stop, sck_rise, sck_fall;
    logic unused_tdata_hi;

    assign unused_tdata_hi = ^s_axis_dac_tdata[DAC_WORD_W-1:DAC_DATA_W];

    assign sck_en   = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
    // the rise strike after bit 0's low phase ends the frame instead of clocking a 17th bit
    assign sck_stop = (state_q == ST_SHIFT) && (bit_q == 4'd0);

    spi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sck_en),
        .stop  (sck_stop),
        .sck   (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        dly_d   = dly_q;
        mosi_d  = mosi_q;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_dac_tvalid && tready_q) begin
                    word_d  = build_cmd(CH, BUF, GA_N, SHDN_N,
                                        s_axis_dac_tdata[DAC_DATA_W-1:0]);
                    mosi_d  = word_d[DAC_WORD_W-1];
                    bit_d   = 4'd15;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (sck_rise) begin
                    bit_d   = 4'd15;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    if (bit_q == 4'd0) begin
                        dly_d   = '0;
                        state_d = ST_LDAC;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else if (sck_fall && (bit_q != 4'd0)) begin
                    mosi_d = word_q[bit_q - 4'd1];
                end
            end
            ST_LDAC: begin
                if (dly_q == DLY_W'(LDAC_CLKS - 1)) begin
                    dly_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_GAP: begin
                if (dly_q == DLY_W'(GAP_CLKS - 1)) begin
                    dly_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dly_d   = '0;
                bit_d   = 4'd15;
            end
        endcase

        cs_d     = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
        ldac_d   = (state_d != ST_LDAC);
        tready_d = (state_d == ST_IDLE);
        if (cs_d) begin
            mosi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            bit_q    <= 4'd15;
            dly_q    <= '0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            ldac_q   <= 1'b1;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
            dly_q    <= dly_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            ldac_q   <= ldac_d;
            tready_q <= tready_d;
        end
    end

    assign s_axis_dac_tready = tready_q;
    assign cs                = cs_q;
    assign mosi              = mosi_q;
    assign ldac              = ldac_q;

endmodule

// File: tb/tb_mcp4921_spi_m_axis_sink.sv
// Bench for mcp4921_spi_m_axis_sink: three instances (defaults, config bits set, SCK_DIV=4)
// observed by a cycle monitor that rebuilds each SPI frame and its timing.
module tb_mcp4921_spi_m_axis_sink;

    typedef struct {
        logic [15:0] word;
        int          cs_len;
        int          rises;
        logic        ldac_at_cs;
        int          ldac_len;
    } frame_t;

    typedef struct {
        int          inst;
        logic [15:0] tdata;
        logic [15:0] exp_word;
        int          exp_cs_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  tvalid_a = 3'b000;
    logic [15:0] tdata_a [3];
    wire  [2:0]  tready_w, cs_w, sck_w, mosi_w, ldac_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frame_t      fq [3][$];
    int          hs_q [3][$];
    int          cs_len [3], rises [3], ldac_len [3], mosi_age [3], rise_age [3];
    int          min_su [3] = '{99, 99, 99};
    int          min_ho [3] = '{99, 99, 99};
    int          tr_bad [3] = '{0, 0, 0};
    int          mosi_bad [3] = '{0, 0, 0};
    logic [15:0] sh [3];
    frame_t      pend [3];
    logic        cs_prev [3], sck_prev [3], ldac_prev [3], mosi_prev [3];
    int          half_of [3] = '{5, 5, 2};
    vec_t        vecs [8];
    frame_t      f;

    always #5 clk = ~clk;

    mcp4921_spi_m_axis_sink #(
        .SCK_DIV(10), .CH(1'b0), .BUF(1'b0), .GA_N(1'b1), .SHDN_N(1'b1),
        .LDAC_CLKS(2), .GAP_CLKS(50)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_dac_tdata(tdata_a[0]), .s_axis_dac_tvalid(tvalid_a[0]),
        .s_axis_dac_tready(tready_w[0]),
        .cs(cs_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]), .ldac(ldac_w[0])
    );

    mcp4921_spi_m_axis_sink #(
        .CH(1'b1), .BUF(1'b1), .GA_N(1'b0), .SHDN_N(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_dac_tdata(tdata_a[1]), .s_axis_dac_tvalid(tvalid_a[1]),
        .s_axis_dac_tready(tready_w[1]),
        .cs(cs_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]), .ldac(ldac_w[1])
    );

    mcp4921_spi_m_axis_sink #(
        .SCK_DIV(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_dac_tdata(tdata_a[2]), .s_axis_dac_tvalid(tvalid_a[2]),
        .s_axis_dac_tready(tready_w[2]),
        .cs(cs_w[2]), .sck(sck_w[2]), .mosi(mosi_w[2]), .ldac(ldac_w[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling clk edge, away from DUT updates.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    cs_len[i] = 0; rises[i] = 0; ldac_len[i] = 0; sh[i] = '0;
                    mosi_age[i] = 0; rise_age[i] = 0;
                    cs_prev[i] = 1'b1; sck_prev[i] = 1'b0; ldac_prev[i] = 1'b1; mosi_prev[i] = 1'b0;
                end else begin
                    if (tvalid_a[i] && tready_w[i]) hs_q[i].push_back(cyc);
                    if (tready_w[i] && (!cs_w[i] || !ldac_w[i])) tr_bad[i]++;
                    if (cs_w[i] && mosi_w[i]) mosi_bad[i]++;
                    if (!cs_w[i]) begin
                        cs_len[i]++;
                        rise_age[i]++;
                        if (mosi_w[i] != mosi_prev[i]) begin
                            if (rises[i] > 0 && rise_age[i] < min_ho[i]) min_ho[i] = rise_age[i];
                            mosi_age[i] = 0;
                        end else begin
                            mosi_age[i]++;
                        end
                        if (sck_w[i] && !sck_prev[i]) begin
                            sh[i] = {sh[i][14:0], mosi_w[i]};
                            rises[i]++;
                            if (mosi_age[i] < min_su[i]) min_su[i] = mosi_age[i];
                            rise_age[i] = 0;
                        end
                    end else begin
                        mosi_age[i] = 0;
                    end
                    if (cs_w[i] && !cs_prev[i]) begin
                        pend[i].word = sh[i];
                        pend[i].cs_len = cs_len[i];
                        pend[i].rises = rises[i];
                        pend[i].ldac_at_cs = ldac_w[i];
                        cs_len[i] = 0; rises[i] = 0; sh[i] = '0;
                    end
                    if (!ldac_w[i]) ldac_len[i]++;
                    if (ldac_w[i] && !ldac_prev[i]) begin
                        pend[i].ldac_len = ldac_len[i];
                        fq[i].push_back(pend[i]);
                        ldac_len[i] = 0;
                    end
                    cs_prev[i] = cs_w[i]; sck_prev[i] = sck_w[i];
                    ldac_prev[i] = ldac_w[i]; mosi_prev[i] = mosi_w[i];
                end
            end
        end
    end

    task automatic wait_hs(input int i);
        int n = 0;
        while (!(tvalid_a[i] && tready_w[i]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_wait", 32'(n < 1000), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int i, input int k);
        int n = 0;
        while (fq[i].size() < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", 32'(fq[i].size() >= k), 1);
    endtask

    task automatic pop_frame(input int i, output frame_t fr);
        if (fq[i].size() > 0) fr = fq[i].pop_front();
        else fr = '{16'h0, 0, 0, 1'b1, 0};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'h5A5A, 16'h3A5A, 165};
        vecs[1] = '{0, 16'h8001, 16'h3001, 165};
        vecs[2] = '{1, 16'hF123, 16'hC123, 165};
        vecs[3] = '{1, 16'h0FFF, 16'hCFFF, 165};
        vecs[4] = '{1, 16'h7000, 16'hC000, 165};
        vecs[5] = '{2, 16'h0ABC, 16'h3ABC, 66};
        vecs[6] = '{2, 16'hFFFF, 16'h3FFF, 66};
        vecs[7] = '{2, 16'h0001, 16'h3001, 66};
        for (int i = 0; i < 3; i++) tdata_a[i] = 16'h0000;

        // Reset state, then tready one clock after release with tvalid already high
        tdata_a[0]  = 16'h0ABC;
        tvalid_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("reset_outputs", {27'd0, tready_w[i], cs_w[i], sck_w[i], mosi_w[i], ldac_w[i]}, 32'b01001);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("tready_after_reset", 32'(tready_w[i]), 1);

        // Back-to-back frames with tvalid held; mid-frame input churn on the third
        wait_hs(0);
        tdata_a[0] = 16'h0FFF;
        wait_hs(0);
        tdata_a[0] = 16'h0000;
        wait_hs(0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            tvalid_a[0] = 1'($urandom_range(0, 1));
            tdata_a[0]  = 16'($urandom);
        end
        tvalid_a[0] = 1'b0;
        wait_frames(0, 3);
        chk("b2b_handshakes", hs_q[0].size(), 3);
        if (hs_q[0].size() >= 3) begin
            chk("b2b_spacing_1", 32'(hs_q[0][1] - hs_q[0][0]), 218);
            chk("b2b_spacing_2", 32'(hs_q[0][2] - hs_q[0][1]), 218);
        end
        pop_frame(0, f);
        chk("frame_0ABC_word", f.word, 16'h3ABC);
        chk("frame_0ABC_cs_len", f.cs_len, 165);
        chk("frame_0ABC_rises", f.rises, 16);
        chk("frame_0ABC_ldac", {f.ldac_at_cs, 31'(f.ldac_len)}, {1'b0, 31'd2});
        pop_frame(0, f);
        chk("frame_0FFF_word", f.word, 16'h3FFF);
        chk("frame_0FFF_cs_len", f.cs_len, 165);
        pop_frame(0, f);
        chk("frame_churn_word", f.word, 16'h3000);
        chk("frame_churn_cs_len", f.cs_len, 165);
        chk("frame_churn_rises", f.rises, 16);
        chk("no_extra_frame", fq[0].size(), 0);
        hs_q[0].delete();

        // Table-driven single frames across the three configurations
        for (int k = 0; k < 8; k++) begin
            tdata_a[vecs[k].inst]  = vecs[k].tdata;
            tvalid_a[vecs[k].inst] = 1'b1;
            wait_hs(vecs[k].inst);
            tvalid_a[vecs[k].inst] = 1'b0;
            wait_frames(vecs[k].inst, 1);
            pop_frame(vecs[k].inst, f);
            chk("vec_word", f.word, vecs[k].exp_word);
            chk("vec_cs_len", f.cs_len, vecs[k].exp_cs_len);
            chk("vec_rises", f.rises, 16);
            chk("vec_ldac", {f.ldac_at_cs, 31'(f.ldac_len)}, {1'b0, 31'd2});
        end

        // Asynchronous reset during bit 7's high phase
        repeat (80) @(negedge clk);
        tdata_a[0]  = 16'h0ABC;
        tvalid_a[0] = 1'b1;
        wait_hs(0);
        tvalid_a[0] = 1'b0;
        begin
            int n = 0;
            while (rises[0] != 9 && n < 1000) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("reach_bit7", 32'(n < 1000), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            {27'd0, tready_w[0], cs_w[0], sck_w[0], mosi_w[0], ldac_w[0]}, 32'b01001);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_partial_frame", fq[0].size(), 0);
        tdata_a[0]  = 16'h0555;
        tvalid_a[0] = 1'b1;
        wait_hs(0);
        tvalid_a[0] = 1'b0;
        wait_frames(0, 1);
        pop_frame(0, f);
        chk("post_reset_word", f.word, 16'h3555);
        chk("post_reset_rises", f.rises, 16);
        chk("post_reset_cs_len", f.cs_len, 165);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("tready_during_frame", tr_bad[i], 0);
            chk("mosi_high_while_cs_high", mosi_bad[i], 0);
            chk("mosi_setup_before_rise", min_su[i], half_of[i]);
            chk("mosi_hold_after_rise", min_ho[i], half_of[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
